// File: rtl/counter_seq_if.sv
// counter_seq_if: control/status bundle between the top-level run controls,
// the run controller (slave side) and the driven up-counter.
// The master side supplies start/stop/pause, the run parameters and the
// counter feedback; the slave side returns the counter strobes and status.
interface counter_seq_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 16
);
  logic               start;
  logic               stop;
  logic               pause;
  logic [WIDTH-1:0]   limit;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   count;
  logic               cnt_en;
  logic               cnt_clr;
  logic               busy;
  logic               done;
  logic [1:0]         state;

  modport master (
    output start, stop, pause, limit, presc, count,
    input  cnt_en, cnt_clr, busy, done, state
  );

  modport slave (
    input  start, stop, pause, limit, presc, count,
    output cnt_en, cnt_clr, busy, done, state
  );
endinterface

// File: rtl/counter_seq.sv
// counter_seq: run controller for the lab up-counter.
// A start request clears the counter, then single-cycle increment enables
// are issued every presc_q+1 unpaused cycles until the counter's feedback
// value equals the captured limit, after which completion is reported.
// Optional build macro: COUNTER_SEQ_AUTORELOAD_EN -- at the limit the run
// pulses done (combinationally) and re-enters CLEAR, repeating until stop
// or reset; the DONE state is then never entered.
module counter_seq #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  counter_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [PRESC_W-1:0] PC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   LIM_ZERO = {WIDTH{1'b0}};

  // registered state
  logic [1:0]         state_r;
  logic [PRESC_W-1:0] pc_r;
  logic [WIDTH-1:0]   limit_q_r;
  logic [PRESC_W-1:0] presc_q_r;
  logic               busy_r;
  logic               clr_r;

  // combinational helpers
  logic [1:0]         state_next_s;
  logic [PRESC_W-1:0] pc_next_s;
  logic               in_run_s;
  logic               at_limit_s;
  logic               tick_s;
  logic               cnt_en_s;
  logic               capture_s;

  // terminal compare against the live counter value and prescaler tick
  always_comb begin
    in_run_s   = (state_r == ST_RUN);
    at_limit_s = (bus.count == limit_q_r);
    tick_s     = (pc_r == presc_q_r);
    capture_s  = (state_r == ST_IDLE) && bus.start;
  end

  // increment enable: never in the cycle the limit is seen, so no overshoot
  always_comb begin
    cnt_en_s = in_run_s && !bus.stop && !at_limit_s && !bus.pause && tick_s;
  end

  // next-state selection; stop outranks the limit, the limit outranks pause
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_next_s = ST_CLEAR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (bus.stop) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_next_s = ST_IDLE;
        end else if (at_limit_s) begin
`ifdef COUNTER_SEQ_AUTORELOAD_EN
          state_next_s = ST_CLEAR;
`else
          state_next_s = ST_DONE;
`endif
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // prescaler: cleared outside RUN, held while paused, reset on each tick
  always_comb begin
    pc_next_s = pc_r;
    case (state_r)
      ST_RUN: begin
        if (bus.stop || at_limit_s) begin
          pc_next_s = PC_ZERO;
        end else if (bus.pause) begin
          pc_next_s = pc_r;
        end else if (tick_s) begin
          pc_next_s = PC_ZERO;
        end else begin
          pc_next_s = pc_r + PC_ONE;
        end
      end
      ST_IDLE, ST_CLEAR, ST_DONE: begin
        pc_next_s = PC_ZERO;
      end
      default: begin
        pc_next_s = PC_ZERO;
      end
    endcase
  end

  // state register and registered busy/clear strobes decoded from next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      clr_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_CLEAR) || (state_next_s == ST_RUN);
      clr_r   <= (state_next_s == ST_CLEAR);
    end
  end

  // prescaler counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r <= PC_ZERO;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // run parameters are sampled only when a start is accepted in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      limit_q_r <= LIM_ZERO;
      presc_q_r <= PC_ZERO;
    end else if (capture_s) begin
      limit_q_r <= bus.limit;
      presc_q_r <= bus.presc;
    end else begin
      limit_q_r <= limit_q_r;
      presc_q_r <= presc_q_r;
    end
  end

`ifdef COUNTER_SEQ_AUTORELOAD_EN
  logic done_s;

  // completion is flagged in the RUN cycle that sees the limit
  always_comb begin
    done_s = in_run_s && !bus.stop && at_limit_s;
  end

  assign bus.done = done_s;
`else
  logic done_r;

  // one-cycle completion pulse while in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_next_s == ST_DONE);
    end
  end

  assign bus.done = done_r;
`endif

  assign bus.cnt_en  = cnt_en_s;
  assign bus.cnt_clr = clr_r;
  assign bus.busy    = busy_r;
  assign bus.state   = state_r;

endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: directed bench for counter_seq with a behavioural model of
// the driven up-counter closing the count feedback loop.
// Cycle c of a scenario is the clock period in which inputs are driven
// (just after the rising edge) and outputs are sampled (falling edge);
// the start request is always in cycle 0.
module tb_counter_seq;

  logic       clk;
  logic       rst;
  logic [7:0] cnt_m;
  logic [5:0] obs;
  int         n_vec;
  int         n_bad;

  counter_seq_if #(.WIDTH(8), .PRESC_W(16)) bus ();

  counter_seq #(.WIDTH(8), .PRESC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lab up-counter: synchronous clear has priority over enable
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_m <= 8'hA5;
    end else if (bus.cnt_clr) begin
      cnt_m <= 8'd0;
    end else if (bus.cnt_en) begin
      cnt_m <= cnt_m + 8'd1;
    end
  end

  assign bus.count = cnt_m;
  assign obs = {bus.state, bus.busy, bus.cnt_clr, bus.cnt_en, bus.done};

  // expected {state, busy, cnt_clr, cnt_en, done} for the one-shot build
  function automatic logic [5:0] mk_exp(input logic [1:0] es, input logic een);
    mk_exp = {es, (es == 2'd1) || (es == 2'd2), es == 2'd1, een, es == 2'd3};
  endfunction

  task automatic drive(input logic s, input logic sp, input logic pa);
    @(posedge clk);
    #1;
    bus.start = s;
    bus.stop  = sp;
    bus.pause = pa;
    @(negedge clk);
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.limit = 8'd0; bus.presc = 16'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (obs !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_init got %b exp %b", obs, 6'b0);
    end
    rst = 1'b1;
    // mid-run reset with cnt_en high
    bus.limit = 8'd5;
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, 1'b0, 1'b0);
    end
    n_vec++;
    if (obs !== mk_exp(2'd2, 1'b1)) begin
      n_bad++;
      $display("FAIL reset_prerun got %b exp %b", obs, mk_exp(2'd2, 1'b1));
    end
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (obs !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_async got %b exp %b", obs, 6'b0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b0);
      n_vec++;
      if (obs !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_hold c=%0d got %b exp %b", c, obs, 6'b0);
      end
    end
  endtask

  task automatic test_basic;
    logic [1:0] es;
    bus.limit = 8'd3; bus.presc = 16'd0;
    for (int c = 0; c < 9; c++) begin
      drive(c == 0, 1'b0, 1'b0);
      es = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : (c <= 5) ? 2'd2 : (c == 6) ? 2'd3 : 2'd0;
      n_vec++;
      if (obs !== mk_exp(es, (c >= 2) && (c <= 4))) begin
        n_bad++;
        $display("FAIL basic c=%0d got %b exp %b", c, obs, mk_exp(es, (c >= 2) && (c <= 4)));
      end
      if (c == 5) begin
        n_vec++;
        if (cnt_m !== 8'd3) begin
          n_bad++;
          $display("FAIL basic_count got %0d exp 3", cnt_m);
        end
      end
    end
  endtask

  task automatic test_presc;
    logic [1:0] es;
    bus.limit = 8'd2; bus.presc = 16'd2;
    for (int c = 0; c < 12; c++) begin
      drive(c == 0, 1'b0, 1'b0);
      if (c == 3) bus.limit = 8'd200;
      es = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : (c <= 8) ? 2'd2 : (c == 9) ? 2'd3 : 2'd0;
      n_vec++;
      if (obs !== mk_exp(es, (c == 4) || (c == 7))) begin
        n_bad++;
        $display("FAIL presc2 c=%0d got %b exp %b", c, obs, mk_exp(es, (c == 4) || (c == 7)));
      end
      if (c == 8) begin
        n_vec++;
        if (cnt_m !== 8'd2) begin
          n_bad++;
          $display("FAIL presc2_count got %0d exp 2", cnt_m);
        end
      end
    end
    bus.limit = 8'd0;
  endtask

  task automatic test_presc1;
    logic [1:0] es;
    bus.limit = 8'd2; bus.presc = 16'd1;
    for (int c = 0; c < 9; c++) begin
      drive(c == 0, 1'b0, 1'b0);
      es = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : (c <= 6) ? 2'd2 : (c == 7) ? 2'd3 : 2'd0;
      n_vec++;
      if (obs !== mk_exp(es, (c == 3) || (c == 5))) begin
        n_bad++;
        $display("FAIL presc1 c=%0d got %b exp %b", c, obs, mk_exp(es, (c == 3) || (c == 5)));
      end
    end
  endtask

  task automatic test_pause;
    logic [1:0] es;
    logic       een;
    bus.limit = 8'd4; bus.presc = 16'd0;
    for (int c = 0; c < 13; c++) begin
      drive(c == 0, 1'b0, (c >= 3) && (c <= 5));
      es  = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : (c <= 9) ? 2'd2 : (c == 10) ? 2'd3 : 2'd0;
      een = (c == 2) || ((c >= 6) && (c <= 8));
      n_vec++;
      if (obs !== mk_exp(es, een)) begin
        n_bad++;
        $display("FAIL pause c=%0d got %b exp %b", c, obs, mk_exp(es, een));
      end
    end
    bus.pause = 1'b0;
  endtask

  task automatic test_stop;
    logic [1:0] es;
    bus.limit = 8'd4; bus.presc = 16'd0;
    for (int c = 0; c < 7; c++) begin
      drive(c == 0, c == 3, 1'b0);
      es = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : (c <= 3) ? 2'd2 : 2'd0;
      n_vec++;
      if (obs !== mk_exp(es, c == 2)) begin
        n_bad++;
        $display("FAIL stop_run c=%0d got %b exp %b", c, obs, mk_exp(es, c == 2));
      end
      if (c >= 4) begin
        n_vec++;
        if (cnt_m !== 8'd1) begin
          n_bad++;
          $display("FAIL stop_count c=%0d got %0d exp 1", c, cnt_m);
        end
      end
    end
    // stop while in CLEAR: clear still driven, no run, no done
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, c == 1, 1'b0);
      es = (c == 1) ? 2'd1 : 2'd0;
      n_vec++;
      if (obs !== mk_exp(es, 1'b0)) begin
        n_bad++;
        $display("FAIL stop_clear c=%0d got %b exp %b", c, obs, mk_exp(es, 1'b0));
      end
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_limit0_back_to_back;
    logic [1:0] es;
    bus.limit = 8'd0; bus.presc = 16'd3;
    for (int c = 0; c < 10; c++) begin
      drive(c <= 4, 1'b0, 1'b0);
      case (c)
        1, 5:    es = 2'd1;
        2, 6:    es = 2'd2;
        3, 7:    es = 2'd3;
        default: es = 2'd0;
      endcase
      n_vec++;
      if (obs !== mk_exp(es, 1'b0)) begin
        n_bad++;
        $display("FAIL limit0 c=%0d got %b exp %b", c, obs, mk_exp(es, 1'b0));
      end
    end
  endtask

  task automatic test_autoreload;
    logic [1:0] es;
    logic       een;
    logic [5:0] ex;
    bus.limit = 8'd2; bus.presc = 16'd0;
    for (int c = 0; c < 13; c++) begin
      drive(c == 0, c == 10, 1'b0);
      es  = (c == 0) ? 2'd0 : ((c == 1) || (c == 5) || (c == 9)) ? 2'd1 :
            (c <= 10) ? 2'd2 : 2'd0;
      een = (c == 2) || (c == 3) || (c == 6) || (c == 7);
      ex  = mk_exp(es, een) | {5'b0, (c == 4) || (c == 8)};
      n_vec++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL autoreload c=%0d got %b exp %b", c, obs, ex);
      end
    end
    bus.stop = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
`ifdef COUNTER_SEQ_AUTORELOAD_EN
    test_autoreload();
`else
    test_basic();
    test_presc();
    test_presc1();
    test_pause();
    test_stop();
    test_limit0_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
